// File: rtl/uart_tx_queue.sv
// Command-byte queue feeding the UART dataIn bus: buffers producer bytes, presents
// one at a time as a held level, pops on the UART accept pulse, 0x00 when idle.
module uart_tx_queue #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_bits,
  output logic          in_ready,
  output logic [7:0]    tx_bits,
  input  logic          tx_ready,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          reject_pulse,
  output logic          overflow_pulse,
  output logic          spurious_pulse
);

  localparam int PW       = $clog2(DEPTH);
  localparam int GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic          r_reject, r_overflow, r_spurious;
  logic          w_full, w_sendable, w_push, w_pop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_sendable = (in_bits[1:0] != 2'b00);
  assign w_push     = in_valid & w_sendable & ~w_full;
  assign w_pop      = (r_state == S_PRESENT) & tx_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  // Storage is never reset; an empty queue never presents, so stale bytes are harmless.
  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wr_ptr] <= in_bits;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_reject   <= 1'b0;
      r_overflow <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= w_count_nxt;
      r_state    <= w_state_nxt;
      r_gap      <= w_gap_nxt;
      r_reject   <= in_valid & ~w_sendable;
      r_overflow <= in_valid & w_sendable & w_full;
      r_spurious <= tx_ready & (r_state != S_PRESENT);
    end
  end

  // IDLE/GAP wake on the registered count, so a same-cycle push adds one cycle of latency.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0)
          w_state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (w_pop) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GW'(GAP_LOAD);
          end else if (w_count_nxt != '0) begin
            w_state_nxt = S_PRESENT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0)
          w_state_nxt = (r_count != '0) ? S_PRESENT : S_IDLE;
        else
          w_gap_nxt = r_gap - GW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_bits        = (r_state == S_PRESENT) ? r_mem[r_rd_ptr] : 8'h00;
  assign count          = r_count;
  assign empty          = (r_count == '0);
  assign full           = w_full;
  assign in_ready       = ~w_full;
  assign reject_pulse   = r_reject;
  assign overflow_pulse = r_overflow;
  assign spurious_pulse = r_spurious;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: vector table plus scoreboard sequences on a no-gap
// instance (DEPTH=8) and a GAP_CYCLES=3 instance sharing the same stimulus.
module tb_uart_tx_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_bits = 8'h00;
  logic       tx_ready = 1'b0;

  logic       o0_in_ready, o0_empty, o0_full, o0_rej, o0_ovf, o0_spur;
  logic [7:0] o0_tx;
  logic [3:0] o0_count;
  logic       o3_in_ready, o3_empty, o3_full, o3_rej, o3_ovf, o3_spur;
  logic [7:0] o3_tx;
  logic [3:0] o3_count;

  int n_cmp = 0;
  int n_fail = 0;
  int mcount = 0;
  logic [7:0] sb_q[$];

  always #5 clock = ~clock;

  uart_tx_queue #(.DEPTH(8), .GAP_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
    .in_ready(o0_in_ready), .tx_bits(o0_tx), .tx_ready(tx_ready), .count(o0_count),
    .empty(o0_empty), .full(o0_full), .reject_pulse(o0_rej),
    .overflow_pulse(o0_ovf), .spurious_pulse(o0_spur));

  uart_tx_queue #(.DEPTH(8), .GAP_CYCLES(3)) u_dut3 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
    .in_ready(o3_in_ready), .tx_bits(o3_tx), .tx_ready(tx_ready), .count(o3_count),
    .empty(o3_empty), .full(o3_full), .reject_pulse(o3_rej),
    .overflow_pulse(o3_ovf), .spurious_pulse(o3_spur));

  typedef struct {
    logic       iv;
    logic [7:0] ib;
    logic       tr;
    logic [7:0] e_tx;
    int         e_cnt;
    logic       e_empty, e_full, e_rej, e_ovf, e_spur;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_bits = 8'h00; tx_ready = 1'b0;
    step();
    reset = 1'b0;
    mcount = 0;
    sb_q.delete();
  endtask

  task automatic push_sb(input logic [7:0] b);
    in_valid = 1'b1; in_bits = b;
    if (b[1:0] != 2'b00 && mcount < 8) begin
      sb_q.push_back(b);
      mcount++;
    end
    step();
    in_valid = 1'b0; in_bits = 8'h00;
    check($sformatf("push %0h count", b), o0_count, mcount);
  endtask

  task automatic pop_sb();
    logic [7:0] exp_b;
    if (sb_q.size() == 0) begin
      check("scoreboard underflow", 1, 0);
    end else begin
      exp_b = sb_q.pop_front();
      check($sformatf("pop order %0h", exp_b), o0_tx, exp_b);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      mcount--;
      check("pop count", o0_count, mcount);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            iv  ib     tr  e_tx   cnt emp full rej ovf spur
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h15, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h15, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h15, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h14, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h05, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h06, 1'b0, 8'h05, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h07, 1'b0, 8'h05, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h06, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 8'h07, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h31, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h31, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h32, 1'b1, 8'h32, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    do_reset();
    check("reset tx_bits", o0_tx, 8'h00);
    check("reset count", o0_count, 0);
    check("reset empty", o0_empty, 1);
    check("reset full", o0_full, 0);
    check("reset in_ready", o0_in_ready, 1);
    check("reset gap-dut tx_bits", o3_tx, 8'h00);

    for (int i = 0; i < 17; i++) begin
      in_valid = vecs[i].iv; in_bits = vecs[i].ib; tx_ready = vecs[i].tr;
      step();
      check($sformatf("vec%0d tx_bits", i), o0_tx, vecs[i].e_tx);
      check($sformatf("vec%0d count", i), o0_count, vecs[i].e_cnt);
      check($sformatf("vec%0d empty", i), o0_empty, vecs[i].e_empty);
      check($sformatf("vec%0d full", i), o0_full, vecs[i].e_full);
      check($sformatf("vec%0d reject", i), o0_rej, vecs[i].e_rej);
      check($sformatf("vec%0d overflow", i), o0_ovf, vecs[i].e_ovf);
      check($sformatf("vec%0d spurious", i), o0_spur, vecs[i].e_spur);
    end

    // Reset while presenting 0x32, with pulse-causing inputs held during the reset edge.
    reset = 1'b1; in_valid = 1'b1; in_bits = 8'h14; tx_ready = 1'b1;
    step();
    check("midreset tx_bits", o0_tx, 8'h00);
    check("midreset count", o0_count, 0);
    check("midreset reject", o0_rej, 0);
    check("midreset spurious", o0_spur, 0);
    check("midreset overflow", o0_ovf, 0);
    reset = 1'b0; in_valid = 1'b0; in_bits = 8'h00; tx_ready = 1'b0;
    step();
    check("postreset tx_bits", o0_tx, 8'h00);
    check("postreset empty", o0_empty, 1);

    // Ordering with slow accepts: byte stays held, no 0x00 between queued bytes.
    do_reset();
    push_sb(8'h05); push_sb(8'h06); push_sb(8'h07);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 20; c++) begin
        check($sformatf("held byte %0d nonzero", k), (o0_tx != 8'h00), 1);
        step();
      end
      pop_sb();
    end
    check("order end tx_bits", o0_tx, 8'h00);
    check("order end empty", o0_empty, 1);

    // Full, overflow and pointer wrap.
    do_reset();
    push_sb(8'h01); push_sb(8'h02); push_sb(8'h03); push_sb(8'h05);
    push_sb(8'h06); push_sb(8'h07); push_sb(8'h09); push_sb(8'h0A);
    check("full flag", o0_full, 1);
    check("full in_ready", o0_in_ready, 0);
    push_sb(8'h0B);
    check("overflow pulse", o0_ovf, 1);
    step();
    check("overflow pulse clears", o0_ovf, 0);
    for (int k = 0; k < 4; k++) pop_sb();
    push_sb(8'h0D); push_sb(8'h0E); push_sb(8'h0F); push_sb(8'h11);
    check("refill full", o0_full, 1);
    for (int k = 0; k < 8; k++) pop_sb();
    check("wrap drained empty", o0_empty, 1);
    check("wrap drained tx_bits", o0_tx, 8'h00);

    // Inter-byte gap on the GAP_CYCLES=3 instance.
    do_reset();
    in_valid = 1'b1; in_bits = 8'h21;
    step();
    in_bits = 8'h22;
    step();
    in_valid = 1'b0; in_bits = 8'h00;
    check("gap first byte", o3_tx, 8'h21);
    check("gap count2", o3_count, 2);
    tx_ready = 1'b1;
    step();
    check("gap cycle1 tx", o3_tx, 8'h00);
    check("gap cycle1 count", o3_count, 1);
    step();
    tx_ready = 1'b0;
    check("gap cycle2 tx", o3_tx, 8'h00);
    check("gap spurious", o3_spur, 1);
    check("gap no pop", o3_count, 1);
    step();
    check("gap cycle3 tx", o3_tx, 8'h00);
    check("gap spurious clears", o3_spur, 0);
    step();
    check("gap second byte", o3_tx, 8'h22);
    check("gap second count", o3_count, 1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("gap2 tx", o3_tx, 8'h00);
    check("gap2 count", o3_count, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("gap2 idle tx %0d", c), o3_tx, 8'h00);
    end
    check("gap2 empty", o3_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Command-byte buffer placed directly upstream of the UART transmitter's dataIn interface. Game/control logic pushes operation bytes at any rate. The block queues them and presents one at a time on the UART's held-level data bus. It pops on the UART's one-cycle accept pulse and drives 0x00 (idle, "no byte") between bytes, with an optional enforced inter-byte gap. Runs in the UART clock domain (16 x baud).

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
GAP_CYCLES, 0, clock cycles tx_bits is forced to 0x00 after each accepted byte; 0 = no gap
CW, $clog2(DEPTH+1), width of count output (derived)

Ports:
clock  input  1  UART clock, all logic on posedge
reset  input  1  synchronous, active-high
in_valid  input  1  producer offers in_bits this cycle
in_bits  input  8  command byte; bits[1:0]==2'b00 is not a sendable byte
in_ready  output  1  = ~full; a push happens when in_valid & in_ready & in_bits[1:0]!=0
tx_bits  output  8  to UART io_dataIn_bits; 0x00 when nothing is presented
tx_ready  input  1  from UART io_dataIn_ready; one-cycle pulse = presented byte accepted
count  output  CW  entries stored, including the one being presented
empty  output  1  count==0
full  output  1  count==DEPTH
reject_pulse  output  1  one-cycle pulse, cycle after an in_valid with in_bits[1:0]==00 (byte discarded)
overflow_pulse  output  1  one-cycle pulse, cycle after in_valid while full (byte discarded)
spurious_pulse  output  1  one-cycle pulse, cycle after tx_ready arrives while state!=PRESENT

Behaviour:
- Reset, synchronous, active-high: rd_ptr=wr_ptr=0, count=0, state=IDLE, gap counter=0, all pulses=0.
  - After the reset edge: tx_bits=0x00, empty=1, full=0, in_ready=1.
  - Memory contents are not cleared.
  - Reset mid-transmission drops all queued bytes. The UART continues any byte it has already latched.
- Storage: circular buffer. Pointers wrap modulo DEPTH. count is incremented on push, decremented on pop, and unchanged on simultaneous push+pop.
- Push rules:
  - in_valid & full: no write; overflow_pulse.
  - in_valid & bits[1:0]==00: no write; reject_pulse. Reject takes precedence if both apply.
  - Push and pop in the same cycle are allowed whenever not full. The written slot is never the slot being presented.
- State machine, registered, transitions on posedge:
  - IDLE: tx_bits=0x00. Go to PRESENT if count!=0, using the registered count, not the same-cycle push.
  - PRESENT: tx_bits=mem[rd_ptr], combinational from registered state and pointer, stable while in this state.
    - On tx_ready: pop (rd_ptr++).
    - Then go to GAP if GAP_CYCLES>0 (load counter=GAP_CYCLES-1).
    - Else go to PRESENT if count-1+push>0, else IDLE.
  - GAP: tx_bits=0x00; counter decrements each cycle. At 0, go to PRESENT if count!=0, else IDLE.
- Latency: a byte pushed on edge N into an empty, idle queue is presented on tx_bits after edge N+1.
- tx_ready while IDLE or GAP: ignored (no pop); spurious_pulse is raised.
- tx_bits never carries a byte with bits[1:0]==00, so UART valid equals "state==PRESENT".

Test Plan:
- Single byte: reset, push 0x15 -> tx_bits=0x00 the cycle after the push, then 0x15. Pulse tx_ready -> next cycle tx_bits=0x00, count=0, empty=1.
- Ordering and back-to-back (GAP_CYCLES=0): push 0x05,0x06,0x07 on consecutive cycles. Three tx_ready pulses 20 cycles apart -> tx_bits shows 0x05, 0x06, 0x07 with no 0x00 between them, then 0x00.
- Full/overflow/wrap (DEPTH=8):
  - Push 0x01..0x08 (all low bits !=0; use 0x01,0x02,0x03,0x05,0x06,0x07,0x09,0x0A) -> full=1, in_ready=0.
  - 9th push 0x0B -> overflow_pulse=1, count stays 8.
  - Drain 4, push 4 more -> bytes emerge in exact push order across the pointer wrap.
- Reject: push 0x14 (low bits 00) -> reject_pulse=1, count unchanged, tx_bits stays 0x00.
- Gap (GAP_CYCLES=3): queue 0x21,0x22; accept 0x21 -> tx_bits=0x00 for exactly 3 cycles, then 0x22. A tx_ready during the gap -> spurious_pulse, 0x22 not popped.
- Simultaneous push+pop and reset: with count=1 presenting 0x31, push 0x32 in the same cycle as tx_ready -> count stays 1, next tx_bits=0x32. Assert reset while presenting 0x32 -> after that edge tx_bits=0x00, count=0, no pulses.
